temporizador_regressivo: RTL
============================

Name: temporizador_regressivo

Overview:
Loadable, cascadable binary down-counter/timer. It counts a loaded value down to zero on qualified ticks and signals the terminal count. It is the counting-down counterpart to the team's 74163-style up counter and shares that counter's control interface (clr, ld, ent, enp, D) so the two can be swapped in a datapath. It feeds sequence-timing and timeout logic in the experiment datapaths.

Parameters:
N, 4, counter width in bits (N >= 2)

Ports:
clock  in  1  single system clock; all state changes on rising edge
clr  in  1  synchronous reset, active-low; highest priority
ld  in  1  synchronous load, active-low; Q and reload register take D
ent  in  1  count enable T; also gates rbo (cascade input)
enp  in  1  count enable P
auto  in  1  1 = auto-reload on terminal tick; 0 = one-shot
D  in  N  load value
Q  out  N  current count
rbo  out  1  ripple borrow out; combinational, = ent && (Q == 0)
fim  out  1  registered terminal-count pulse, one cycle wide
ativo  out  1  1 while the FSM is in CONTANDO

Behaviour:
- Clock/reset: one clock ("clock"). Reset "clr" is synchronous and active-low. Priority at each rising edge: clr, then ld, then count.
- Internal state: Q, reload register R[N-1:0], FSM {OCIOSO, CONTANDO, FIM}, and fim flop.
- clr=0: Q=0, R=0, state OCIOSO, fim=0. This applies from any state, including mid-count.
- ld=0 (clr=1): Q<=D, R<=D, state<=CONTANDO, fim<=0. A load is accepted in every state, including restart during CONTANDO or FIM.
- Tick is defined as ent && enp, evaluated only in CONTANDO.
  - Q != 0: Q<=Q-1.
  - Q == 0 (terminal tick): fim<=1 for exactly the next cycle.
    - auto=1: Q<=R and the FSM stays in CONTANDO.
    - auto=0: Q stays 0 and state<=FIM.
- No tick in CONTANDO: Q holds and fim<=0.
- OCIOSO and FIM: Q holds and ticks are ignored; fim<=0, except for the single pulse cycle that follows a terminal tick.
- Period: D+1 ticks from load to terminal tick. D=0 with auto=1 gives fim on every tick.
- The decrement never wraps; Q underflow is impossible by construction.
- rbo is purely combinational from Q and ent and is independent of enp and FSM state. This matches rco usage when building wider cascaded chains.
- ativo = (state == CONTANDO). It is registered-state derived, with no combinational path from inputs.
- Reset values: Q=0, fim=0, ativo=0. rbo=ent at reset, since Q=0.
- auto is sampled only on the terminal tick; changing it mid-count has no other effect.

Optional Feature:
TEMPORIZADOR_PAUSA_EN
- Defined:
  - Adds input port pausa (1 bit) and FSM state PAUSADO.
  - In CONTANDO, pausa=1 moves to PAUSADO on the next edge; Q freezes and ticks are ignored.
  - In PAUSADO, pausa=0 returns to CONTANDO on the next edge.
  - ativo=0 in PAUSADO.
  - clr and ld keep their priority over pause. A load in PAUSADO goes to CONTANDO.
  - pausa is ignored in OCIOSO and FIM.
- Undefined: no pausa port and no PAUSADO state; behaviour is exactly as above.

Test Plan:
- Reset mid-count: load D=7, tick twice (Q=5), then clr=0 for one edge -> Q=0, ativo=0, fim=0. Ticks afterwards leave Q=0 (OCIOSO).
- One-shot: auto=0, ld=0 with D=3, then ent=enp=1 -> Q=3,2,1,0 on successive edges. fim=1 only in the cycle after the 4th tick edge; ativo falls in that same cycle; Q stays 0.
- Auto-reload: auto=1, D=2, continuous ticks -> Q=2,1,0,2,1,0,2. fim pulses once per 3 ticks and ativo stays 1.
- Enables and borrow: Q=0 in CONTANDO, ent=1, enp=0 -> Q holds, rbo=1, fim=0. With ent=0, rbo=0. With Q=4, ent=1, rbo=0.
- Priority: clr=0 and ld=0 together with D=9 -> Q=0, OCIOSO. ld=0 with D=5 while in FIM -> Q=5, ativo=1. ld=0 with D=6 mid-count at Q=2 -> Q=6, no fim.
- TEMPORIZADOR_PAUSA_EN: D=5, two ticks (Q=3), pausa=1 for 4 cycles with ticks -> Q stays 3 and ativo=0. pausa=0 -> counts resume 2,1,0, then fim.

Source files
------------

// File: rtl/temporizador_regressivo.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_regressivo
//  Description : Loadable, cascadable binary down-counter/timer. Counts a
//                loaded value down to zero on qualified ticks (ent && enp),
//                pulses fim for one cycle on the terminal tick, and either
//                reloads (auto=1) or stops (auto=0). Control interface
//                mirrors the 74163-style up counter (clr, ld, ent, enp, D).
//  Options     : `define TEMPORIZADOR_PAUSA_EN adds the pausa input and the
//                PAUSADO state (count frozen, ativo low).
//  Revision    : 1.0 - initial release
// ============================================================================
module temporizador_regressivo #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         ld,
    input  logic         ent,
    input  logic         enp,
    input  logic         auto,
`ifdef TEMPORIZADOR_PAUSA_EN
    input  logic         pausa,
`endif
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         rbo,
    output logic         fim,
    output logic         ativo
);

    localparam logic [N-1:0] c_zero = '0;
    localparam logic [N-1:0] c_one  = {{(N-1){1'b0}}, 1'b1};

`ifdef TEMPORIZADOR_PAUSA_EN
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        FIM      = 2'd2,
        PAUSADO  = 2'd3
    } estado_t;
`else
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        FIM      = 2'd2
    } estado_t;
`endif

    logic [N-1:0] r_q;
    logic [N-1:0] r_recarga;
    estado_t      r_estado;
    logic         r_fim;

    logic         w_tick;
    logic         w_zero;
    logic         w_pausa;

`ifdef TEMPORIZADOR_PAUSA_EN
    assign w_pausa = pausa;
`else
    assign w_pausa = 1'b0;
`endif

    assign w_tick = ent && enp;
    assign w_zero = (r_q == c_zero);

    // Counter, reload register, FSM and terminal pulse: clr > ld > count
    always_ff @(posedge clock) begin
        if (!clr) begin
            r_q       <= c_zero;
            r_recarga <= c_zero;
            r_estado  <= OCIOSO;
            r_fim     <= 1'b0;
        end else if (!ld) begin
            r_q       <= D;
            r_recarga <= D;
            r_estado  <= CONTANDO;
            r_fim     <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_estado)
                CONTANDO: begin
                    if (w_pausa) begin
`ifdef TEMPORIZADOR_PAUSA_EN
                        r_estado <= PAUSADO;
`endif
                    end else if (w_tick) begin
                        if (!w_zero) begin
                            r_q <= r_q - c_one;
                        end else begin
                            // Terminal tick: auto is only looked at here
                            r_fim <= 1'b1;
                            if (auto) begin
                                r_q <= r_recarga;
                            end else begin
                                r_estado <= FIM;
                            end
                        end
                    end
                end
`ifdef TEMPORIZADOR_PAUSA_EN
                PAUSADO: begin
                    if (!w_pausa) begin
                        r_estado <= CONTANDO;
                    end
                end
`endif
                default: begin
                    // OCIOSO / FIM: hold Q, ignore ticks
                end
            endcase
        end
    end

    assign Q     = r_q;
    assign fim   = r_fim;
    assign ativo = (r_estado == CONTANDO);
    // Borrow out for cascading: independent of enp and FSM state
    assign rbo   = ent && w_zero;

endmodule
`default_nettype wire
